// File: rtl/sram_like_bridge_pkg.sv
// sram_like_bridge_pkg: FSM encodings and SRAM-like bus size codes shared by the bridge files.
package sram_like_bridge_pkg;
  typedef enum logic [1:0] {BRG_IDLE = 2'd0, BRG_REQ = 2'd1, BRG_WAIT = 2'd2} brg_state_e;
  localparam logic [1:0] BUS_SIZE_B = 2'd0;
  localparam logic [1:0] BUS_SIZE_H = 2'd1;
  localparam logic [1:0] BUS_SIZE_W = 2'd2;
endpackage

// File: rtl/sram_like_bridge_size_dec.sv
// sram_size_dec: maps byte write enables to bus size and low address bits; unsupported masks fall back to word size.
module sram_size_dec
  import sram_like_bridge_pkg::*;
(
  input  logic [3:0] i_wen,
  input  logic [1:0] i_addr_lo,
  output logic [1:0] o_size,
  output logic [1:0] o_addr_lo
);
  always_comb begin
    o_size    = (i_wen == 4'h0 || i_wen == 4'hf) ? BUS_SIZE_W :
                (i_wen == 4'h3 || i_wen == 4'hc) ? BUS_SIZE_H :
                (i_wen == 4'h1 || i_wen == 4'h2 || i_wen == 4'h4 || i_wen == 4'h8) ? BUS_SIZE_B :
                BUS_SIZE_W;
    o_addr_lo = (i_wen == 4'h0 || i_wen == 4'hf || i_wen == 4'h3 || i_wen == 4'h1) ? 2'd0 :
                (i_wen == 4'hc || i_wen == 4'h4) ? 2'd2 :
                (i_wen == 4'h2) ? 2'd1 :
                (i_wen == 4'h8) ? 2'd3 :
                i_addr_lo;
  end
endmodule

// File: rtl/sram_like_bridge.sv
// sram_like_bridge: serves core inst/data zero-wait SRAM ports over one SRAM-like bus, one txn at a time.
// Optional BRIDGE_PERF_CNT_EN adds perf_stall_cyc / perf_txn_cnt counters.
module sram_like_bridge
  import sram_like_bridge_pkg::*;
#(
  parameter bit DATA_PRIO = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        inst_sram_en,
  input  logic [31:0] inst_sram_addr,
  output logic [31:0] inst_sram_rdata,
  input  logic        data_sram_en,
  input  logic [3:0]  data_sram_wen,
  input  logic [31:0] data_sram_addr,
  input  logic [31:0] data_sram_wdata,
  output logic [31:0] data_sram_rdata,
  output logic        stallreq_bus,
  output logic        bus_req,
  output logic        bus_wr,
  output logic [1:0]  bus_size,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  input  logic        bus_addr_ok,
  input  logic        bus_data_ok,
`ifdef BRIDGE_PERF_CNT_EN
  input  logic [31:0] bus_rdata,
  output logic [31:0] perf_stall_cyc,
  output logic [31:0] perf_txn_cnt
`else
  input  logic [31:0] bus_rdata
`endif
);
  brg_state_e  r_state;
  logic        r_done_i, r_done_d, r_sel_d;
  logic        r_bus_req, r_bus_wr;
  logic [1:0]  r_bus_size;
  logic [31:0] r_bus_addr, r_bus_wdata, r_inst_rdata, r_data_rdata;
  logic        w_pend_i, w_pend_d, w_pick_d, w_cmp, w_cmp_i, w_cmp_d;
  logic [1:0]  w_dsize, w_dlo;
  sram_size_dec u_dec (
    .i_wen    (data_sram_wen),
    .i_addr_lo(data_sram_addr[1:0]),
    .o_size   (w_dsize),
    .o_addr_lo(w_dlo)
  );
  always_comb begin
    w_pend_i = inst_sram_en & ~r_done_i;
    w_pend_d = data_sram_en & ~r_done_d;
    w_pick_d = w_pend_d & (DATA_PRIO | ~w_pend_i);
    w_cmp    = ((r_state == BRG_REQ) & bus_addr_ok & bus_data_ok) | ((r_state == BRG_WAIT) & bus_data_ok);
    w_cmp_i  = w_cmp & ~r_sel_d;
    w_cmp_d  = w_cmp & r_sel_d;
  end
  assign stallreq_bus    = w_pend_i | w_pend_d;
  assign bus_req         = r_bus_req;
  assign bus_wr          = r_bus_wr;
  assign bus_size        = r_bus_size;
  assign bus_addr        = r_bus_addr;
  assign bus_wdata       = r_bus_wdata;
  assign inst_sram_rdata = r_inst_rdata;
  assign data_sram_rdata = r_data_rdata;
  // done flags collapse when the core stops stalling, so a txn finishing after its en dropped is not remembered
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= BRG_IDLE;
      r_done_i     <= 1'b0;
      r_done_d     <= 1'b0;
      r_sel_d      <= 1'b0;
      r_bus_req    <= 1'b0;
      r_bus_wr     <= 1'b0;
      r_bus_size   <= 2'd0;
      r_bus_addr   <= 32'd0;
      r_bus_wdata  <= 32'd0;
      r_inst_rdata <= 32'd0;
      r_data_rdata <= 32'd0;
    end else begin
      r_done_i <= stallreq_bus & (r_done_i | w_cmp_i);
      r_done_d <= stallreq_bus & (r_done_d | w_cmp_d);
      if (w_cmp_i) r_inst_rdata <= bus_rdata;
      if (w_cmp_d & ~r_bus_wr) r_data_rdata <= bus_rdata;
      case (r_state)
        BRG_IDLE: if (stallreq_bus) begin
          r_state     <= BRG_REQ;
          r_bus_req   <= 1'b1;
          r_sel_d     <= w_pick_d;
          r_bus_wr    <= w_pick_d & (|data_sram_wen);
          r_bus_size  <= w_pick_d ? w_dsize : BUS_SIZE_W;
          r_bus_addr  <= w_pick_d ? {data_sram_addr[31:2], w_dlo} : inst_sram_addr;
          r_bus_wdata <= w_pick_d ? data_sram_wdata : 32'd0;
        end
        BRG_REQ: if (bus_addr_ok) begin
          r_bus_req <= 1'b0;
          r_state   <= bus_data_ok ? BRG_IDLE : BRG_WAIT;
        end
        BRG_WAIT: if (bus_data_ok) r_state <= BRG_IDLE;
        default: r_state <= BRG_IDLE;
      endcase
    end
  end
`ifdef BRIDGE_PERF_CNT_EN
  logic [31:0] r_perf_stall, r_perf_txn;
  assign perf_stall_cyc = r_perf_stall;
  assign perf_txn_cnt   = r_perf_txn;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_perf_stall <= 32'd0;
      r_perf_txn   <= 32'd0;
    end else begin
      r_perf_stall <= r_perf_stall + {31'd0, stallreq_bus};
      r_perf_txn   <= r_perf_txn + {31'd0, w_cmp};
    end
  end
`endif
endmodule

// File: tb/tb_sram_like_bridge.sv
// tb_sram_like_bridge: directed self-checking bench for sram_like_bridge (DATA_PRIO=1).
module tb_sram_like_bridge;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        inst_sram_en = 1'b0;
  logic [31:0] inst_sram_addr = 32'd0;
  logic [31:0] inst_sram_rdata;
  logic        data_sram_en = 1'b0;
  logic [3:0]  data_sram_wen = 4'd0;
  logic [31:0] data_sram_addr = 32'd0;
  logic [31:0] data_sram_wdata = 32'd0;
  logic [31:0] data_sram_rdata;
  logic        stallreq_bus, bus_req, bus_wr;
  logic [1:0]  bus_size;
  logic [31:0] bus_addr, bus_wdata;
  logic        bus_addr_ok = 1'b0;
  logic        bus_data_ok = 1'b0;
  logic [31:0] bus_rdata = 32'd0;
`ifdef BRIDGE_PERF_CNT_EN
  logic [31:0] perf_stall_cyc, perf_txn_cnt;
`endif
  int pass_cnt = 0;
  int total_cnt = 0;

  always #5 clk = ~clk;

  sram_like_bridge #(.DATA_PRIO(1'b1)) dut (
    .clk(clk), .rst(rst),
    .inst_sram_en(inst_sram_en), .inst_sram_addr(inst_sram_addr), .inst_sram_rdata(inst_sram_rdata),
    .data_sram_en(data_sram_en), .data_sram_wen(data_sram_wen), .data_sram_addr(data_sram_addr),
    .data_sram_wdata(data_sram_wdata), .data_sram_rdata(data_sram_rdata),
    .stallreq_bus(stallreq_bus), .bus_req(bus_req), .bus_wr(bus_wr), .bus_size(bus_size),
    .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_addr_ok(bus_addr_ok), .bus_data_ok(bus_data_ok),
`ifdef BRIDGE_PERF_CNT_EN
    .bus_rdata(bus_rdata), .perf_stall_cyc(perf_stall_cyc), .perf_txn_cnt(perf_txn_cnt)
`else
    .bus_rdata(bus_rdata)
`endif
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    tick(); tick();
    @(negedge clk);
    total_cnt++; if (stallreq_bus !== 1'b0) $display("FAIL reset_stall got %b exp 0", stallreq_bus); else pass_cnt++;
    total_cnt++; if (bus_req !== 1'b0) $display("FAIL reset_req got %b exp 0", bus_req); else pass_cnt++;
    total_cnt++; if (bus_addr !== 32'd0) $display("FAIL reset_addr got %h exp 0", bus_addr); else pass_cnt++;
    total_cnt++; if (inst_sram_rdata !== 32'd0 || data_sram_rdata !== 32'd0)
      $display("FAIL reset_rdata got %h/%h exp 0/0", inst_sram_rdata, data_sram_rdata); else pass_cnt++;
    tick(); rst = 1'b0;
  endtask

  task automatic test_fetch();
    tick(); inst_sram_en = 1'b1; inst_sram_addr = 32'hBFC00000;
    @(negedge clk);
    total_cnt++; if ({stallreq_bus, bus_req} !== 2'b10) $display("FAIL fetch_idle stall/req got %b exp 10", {stallreq_bus, bus_req}); else pass_cnt++;
    tick(); bus_addr_ok = 1'b1;
    @(negedge clk);
    total_cnt++; if ({stallreq_bus, bus_req, bus_wr, bus_size} !== 5'b11010)
      $display("FAIL fetch_req stall/req/wr/size got %b exp 11010", {stallreq_bus, bus_req, bus_wr, bus_size}); else pass_cnt++;
    total_cnt++; if (bus_addr !== 32'hBFC00000) $display("FAIL fetch_addr got %h exp bfc00000", bus_addr); else pass_cnt++;
    tick(); bus_addr_ok = 1'b0; bus_data_ok = 1'b1; bus_rdata = 32'h24010001;
    @(negedge clk);
    total_cnt++; if ({stallreq_bus, bus_req} !== 2'b10) $display("FAIL fetch_wait stall/req got %b exp 10", {stallreq_bus, bus_req}); else pass_cnt++;
    tick(); bus_data_ok = 1'b0; bus_rdata = 32'h0;
    @(negedge clk);
    total_cnt++; if (stallreq_bus !== 1'b0) $display("FAIL fetch_release stall got %b exp 0", stallreq_bus); else pass_cnt++;
    total_cnt++; if (inst_sram_rdata !== 32'h24010001) $display("FAIL fetch_rdata got %h exp 24010001", inst_sram_rdata); else pass_cnt++;
    tick(); inst_sram_en = 1'b0;
    @(negedge clk);
    total_cnt++; if (inst_sram_rdata !== 32'h24010001 || bus_req !== 1'b0)
      $display("FAIL fetch_hold rdata/req got %h/%b exp 24010001/0", inst_sram_rdata, bus_req); else pass_cnt++;
  endtask

  task automatic test_prio();
    tick();
    inst_sram_en = 1'b1; inst_sram_addr = 32'h00001000;
    data_sram_en = 1'b1; data_sram_wen = 4'h0; data_sram_addr = 32'h00002004;
    @(negedge clk);
    total_cnt++; if (stallreq_bus !== 1'b1) $display("FAIL prio_stall0 got %b exp 1", stallreq_bus); else pass_cnt++;
    tick(); bus_addr_ok = 1'b1; bus_data_ok = 1'b1; bus_rdata = 32'hDDDD0001;
    @(negedge clk);
    total_cnt++; if ({bus_req, bus_wr, bus_addr} !== {2'b10, 32'h00002004})
      $display("FAIL prio_first req/wr/addr got %b/%b/%h exp 1/0/00002004", bus_req, bus_wr, bus_addr); else pass_cnt++;
    tick(); bus_addr_ok = 1'b0; bus_data_ok = 1'b0;
    @(negedge clk);
    total_cnt++; if ({stallreq_bus, bus_req} !== 2'b10) $display("FAIL prio_gap stall/req got %b exp 10", {stallreq_bus, bus_req}); else pass_cnt++;
    total_cnt++; if (data_sram_rdata !== 32'hDDDD0001) $display("FAIL prio_drdata got %h exp dddd0001", data_sram_rdata); else pass_cnt++;
    tick(); bus_addr_ok = 1'b1; bus_data_ok = 1'b1; bus_rdata = 32'h11110002;
    @(negedge clk);
    total_cnt++; if ({bus_req, bus_addr} !== {1'b1, 32'h00001000})
      $display("FAIL prio_second req/addr got %b/%h exp 1/00001000", bus_req, bus_addr); else pass_cnt++;
    tick(); bus_addr_ok = 1'b0; bus_data_ok = 1'b0;
    @(negedge clk);
    total_cnt++; if (stallreq_bus !== 1'b0) $display("FAIL prio_release stall got %b exp 0", stallreq_bus); else pass_cnt++;
    total_cnt++; if (inst_sram_rdata !== 32'h11110002 || data_sram_rdata !== 32'hDDDD0001)
      $display("FAIL prio_rdata got %h/%h exp 11110002/dddd0001", inst_sram_rdata, data_sram_rdata); else pass_cnt++;
    tick(); inst_sram_en = 1'b0; data_sram_en = 1'b0;
  endtask

  task automatic test_store_stall();
    tick();
    data_sram_en = 1'b1; data_sram_wen = 4'b0100; data_sram_addr = 32'h80000010; data_sram_wdata = 32'h00AB0000;
    tick();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      total_cnt++; if ({stallreq_bus, bus_req, bus_wr, bus_size} !== 5'b11100 || bus_addr !== 32'h80000012 || bus_wdata !== 32'h00AB0000)
        $display("FAIL store_hold%0d stall/req/wr/size got %b addr %h wdata %h exp 11100 80000012 00ab0000",
                 i, {stallreq_bus, bus_req, bus_wr, bus_size}, bus_addr, bus_wdata);
      else pass_cnt++;
      tick();
    end
    bus_addr_ok = 1'b1;
    tick(); bus_addr_ok = 1'b0;
    @(negedge clk);
    total_cnt++; if ({stallreq_bus, bus_req} !== 2'b10) $display("FAIL store_wait stall/req got %b exp 10", {stallreq_bus, bus_req}); else pass_cnt++;
    tick(); bus_data_ok = 1'b1; bus_rdata = 32'h55555555;
    tick(); bus_data_ok = 1'b0;
    @(negedge clk);
    total_cnt++; if (stallreq_bus !== 1'b0) $display("FAIL store_release stall got %b exp 0", stallreq_bus); else pass_cnt++;
    total_cnt++; if (data_sram_rdata !== 32'hDDDD0001) $display("FAIL store_rdata_kept got %h exp dddd0001", data_sram_rdata); else pass_cnt++;
    tick(); data_sram_en = 1'b0; data_sram_wen = 4'h0;
  endtask

  task automatic test_half_store();
    tick();
    data_sram_en = 1'b1; data_sram_wen = 4'b1100; data_sram_addr = 32'h00000100; data_sram_wdata = 32'h12340000;
    tick(); bus_addr_ok = 1'b1; bus_data_ok = 1'b1;
    @(negedge clk);
    total_cnt++; if ({bus_wr, bus_size} !== 3'b101 || bus_addr !== 32'h00000102)
      $display("FAIL half_fields wr/size got %b addr %h exp 101 00000102", {bus_wr, bus_size}, bus_addr); else pass_cnt++;
    tick(); bus_addr_ok = 1'b0; bus_data_ok = 1'b0;
    @(negedge clk);
    total_cnt++; if (stallreq_bus !== 1'b0) $display("FAIL half_release stall got %b exp 0", stallreq_bus); else pass_cnt++;
    tick(); data_sram_en = 1'b0; data_sram_wen = 4'h0;
  endtask

  task automatic test_rst_mid();
    tick(); inst_sram_en = 1'b1; inst_sram_addr = 32'h00003000;
    tick(); bus_addr_ok = 1'b1;
    tick(); bus_addr_ok = 1'b0; rst = 1'b1;
    tick(); rst = 1'b0; bus_data_ok = 1'b1; bus_rdata = 32'hDEADBEEF;
    @(negedge clk);
    total_cnt++; if ({stallreq_bus, bus_req} !== 2'b10) $display("FAIL rstmid_after stall/req got %b exp 10", {stallreq_bus, bus_req}); else pass_cnt++;
    tick(); bus_data_ok = 1'b0; inst_sram_en = 1'b0;
    @(negedge clk);
    total_cnt++; if (inst_sram_rdata !== 32'd0) $display("FAIL rstmid_late_dataok rdata got %h exp 0", inst_sram_rdata); else pass_cnt++;
    total_cnt++; if ({stallreq_bus, bus_req} !== 2'b01) $display("FAIL rstmid_reissue stall/req got %b exp 01", {stallreq_bus, bus_req}); else pass_cnt++;
    bus_addr_ok = 1'b1; bus_data_ok = 1'b1; bus_rdata = 32'hCAFE0000;
    tick(); bus_addr_ok = 1'b0; bus_data_ok = 1'b0;
    @(negedge clk);
    total_cnt++; if ({stallreq_bus, bus_req} !== 2'b00 || inst_sram_rdata !== 32'hCAFE0000)
      $display("FAIL rstmid_drain stall/req got %b rdata %h exp 00 cafe0000", {stallreq_bus, bus_req}, inst_sram_rdata); else pass_cnt++;
  endtask

`ifdef BRIDGE_PERF_CNT_EN
  task automatic test_perf();
    tick(); rst = 1'b1;
    tick(); rst = 1'b0;
    @(negedge clk);
    total_cnt++; if (perf_stall_cyc !== 32'd0 || perf_txn_cnt !== 32'd0)
      $display("FAIL perf_reset got %0d/%0d exp 0/0", perf_stall_cyc, perf_txn_cnt); else pass_cnt++;
    tick(); inst_sram_en = 1'b1; inst_sram_addr = 32'hBFC00000;
    tick(); bus_addr_ok = 1'b1;
    tick(); bus_addr_ok = 1'b0; bus_data_ok = 1'b1;
    tick(); bus_data_ok = 1'b0;
    @(negedge clk);
    total_cnt++; if (perf_stall_cyc !== 32'd3 || perf_txn_cnt !== 32'd1)
      $display("FAIL perf_counts got %0d/%0d exp 3/1", perf_stall_cyc, perf_txn_cnt); else pass_cnt++;
    tick(); inst_sram_en = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_fetch();
    test_prio();
    test_store_stall();
    test_half_store();
    test_rst_mid();
`ifdef BRIDGE_PERF_CNT_EN
    test_perf();
`endif
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
